cache_state_array: RTL and testbench
====================================

CACHE_STATE_ARRAY -- requirements
Module: cache_state_array

Interface
REQ-001 The block SHALL have parameter NUM_WAYS, default 2, meaning the number of ways (legal values: 2, 4, 8).
REQ-002 The block SHALL have parameter NUM_SETS, default 8, meaning the number of sets (power of 2, at least 2).
REQ-003 The block SHALL have localparams SET_W = $clog2(NUM_SETS) and WAY_W = $clog2(NUM_WAYS).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 set_sel  input  SET_W  set index for reads, writes and victim lookup.
REQ-007 way_sel  input  WAY_W  way index for writes and valid_sig/dirty_sig.
REQ-008 load  input  1  mark [set_sel][way_sel] valid and clean; advance that set's replacement pointer.
REQ-009 mark_dirty  input  1  set the dirty bit of [set_sel][way_sel].
REQ-010 invalidate  input  1  clear the valid and dirty bits of [set_sel][way_sel].
REQ-011 flush_req  input  1  start a whole-array invalidate.
REQ-012 valid_vec  output  NUM_WAYS  valid bits of set set_sel.
REQ-013 dirty_vec  output  NUM_WAYS  dirty bits of set set_sel.
REQ-014 valid_sig  output  1  valid bit of [set_sel][way_sel].
REQ-015 dirty_sig  output  1  dirty bit of [set_sel][way_sel].
REQ-016 victim_way  output  WAY_W  replacement choice for set set_sel.
REQ-017 flush_busy  output  1  high while a flush walk is in progress.
REQ-018 flush_done  output  1  one-cycle pulse when a flush completes.

Function
REQ-019 valid_vec, dirty_vec, valid_sig, dirty_sig and victim_way SHALL be combinational from the current state; writes SHALL become visible on the cycle after the clock edge.
REQ-020 victim_way SHALL equal the lowest-index invalid way in set_sel; if all ways are valid, it SHALL equal that set's round-robin pointer.
REQ-021 Each set SHALL own one WAY_W-bit round-robin pointer; load SHALL set it to (way_sel+1) mod NUM_WAYS, wrapping from NUM_WAYS-1 to 0.
REQ-022 Same-cycle priority for a given entry SHALL be invalidate > load > mark_dirty.
REQ-023 load together with mark_dirty SHALL leave the entry valid=1 and dirty=1.
REQ-024 mark_dirty on an invalid entry SHALL be ignored (dirty is never 1 while valid is 0).
REQ-025 invalidate SHALL NOT change the replacement pointer.
REQ-026 FSM states SHALL be IDLE, WALK and DONE.
REQ-027 IDLE -> WALK on flush_req=1; a counter flush_idx SHALL be loaded with 0.
REQ-028 In WALK, each cycle SHALL clear the valid and dirty bits of every way in set flush_idx and reset that set's pointer to 0, then increment flush_idx.
REQ-029 WALK -> DONE after set NUM_SETS-1 is cleared; the walk SHALL take exactly NUM_SETS cycles.
REQ-030 DONE SHALL assert flush_done for one cycle, then return to IDLE.
REQ-031 flush_busy SHALL be 1 in WALK and DONE and 0 in IDLE.
REQ-032 While flush_busy=1, load, mark_dirty, invalidate and flush_req SHALL be ignored; reads SHALL still reflect current state.
REQ-033 flush_req in the same cycle as load in IDLE: load SHALL take effect, and the flush SHALL start the next cycle.

Reset
REQ-034 When rst_n=0, all valid bits, dirty bits and pointers SHALL be 0, the FSM SHALL be IDLE, flush_idx SHALL be 0, and flush_busy and flush_done SHALL be 0, asynchronously.
REQ-035 Reset asserted mid-walk SHALL abort the flush; no flush_done pulse SHALL follow.
REQ-036 After reset, victim_way SHALL be 0 for every set.

Verification
REQ-037 Reset, then load set 3 way 0 -> next cycle: valid_vec[3]=2'b01, victim_way=1, dirty_sig=0.
REQ-038 Load set 5 ways 0 then 1 (NUM_WAYS=2), then load way 1 again -> victim_way=0 after way 1, pointer wraps to 0 after way 1 repeat; set 5 all valid, victim follows pointer.
REQ-039 Same cycle invalidate+load+mark_dirty on set 2 way 1 -> entry valid=0, dirty=0; mark_dirty on an invalid entry -> dirty stays 0.
REQ-040 Fill all entries and dirty some, then pulse flush_req -> flush_busy=1 for 9 cycles (8 walk + DONE), flush_done one pulse, all vectors 0, loads during the walk ignored.
REQ-041 Assert rst_n=0 at walk cycle 4 -> outputs 0 immediately, no flush_done; NUM_WAYS=4/NUM_SETS=16 rerun: walk takes 16 cycles.

Source files
------------

// File: rtl/cache_state_array_if.sv
// Request/status bundle for the cache state array: the controller drives
// set/way selects and update strobes, the array returns state views.
interface cache_state_array_if #(
   parameter int NUM_WAYS = 2,
   parameter int NUM_SETS = 8
);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);

   logic [SET_W-1:0]    set_sel;
   logic [WAY_W-1:0]    way_sel;
   logic                load;
   logic                mark_dirty;
   logic                invalidate;
   logic                flush_req;
   logic [NUM_WAYS-1:0] valid_vec;
   logic [NUM_WAYS-1:0] dirty_vec;
   logic                valid_sig;
   logic                dirty_sig;
   logic [WAY_W-1:0]    victim_way;
   logic                flush_busy;
   logic                flush_done;

   modport master (
      output set_sel, way_sel, load, mark_dirty, invalidate, flush_req,
      input  valid_vec, dirty_vec, valid_sig, dirty_sig, victim_way,
             flush_busy, flush_done
   );

   modport slave (
      input  set_sel, way_sel, load, mark_dirty, invalidate, flush_req,
      output valid_vec, dirty_vec, valid_sig, dirty_sig, victim_way,
             flush_busy, flush_done
   );
endinterface

// File: rtl/cache_state_array.sv
// Valid/dirty bits and round-robin replacement pointers for a set-associative
// cache, with a one-set-per-cycle flush walker.
module cache_state_array #(
   parameter int NUM_WAYS = 2,
   parameter int NUM_SETS = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   cache_state_array_if.slave    bus
);
   localparam int SET_W = $clog2(NUM_SETS);
   localparam int WAY_W = $clog2(NUM_WAYS);
   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
   localparam logic [WAY_W-1:0] WAY_ONE  = WAY_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WALK = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [SET_W-1:0]    flush_idx_r;
   logic [SET_W-1:0]    flush_idx_s;
   logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
   logic [NUM_WAYS-1:0] dirty_r [NUM_SETS];
   logic [WAY_W-1:0]    ptr_r   [NUM_SETS];
   logic [NUM_WAYS-1:0] set_valid_s;
   logic [WAY_W-1:0]    victim_s;
   logic                accept_s;

   // Host updates are only honoured while no flush is running.
   assign accept_s = (state_r == IDLE);

   // Flush FSM state and walk index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         flush_idx_r <= '0;
      end else begin
         state_r     <= state_s;
         flush_idx_r <= flush_idx_s;
      end
   end

   // Flush FSM next-state and walk index.
   always_comb begin
      state_s     = state_r;
      flush_idx_s = flush_idx_r;
      case (state_r)
         IDLE: begin
            if (bus.flush_req) begin
               state_s     = WALK;
               flush_idx_s = '0;
            end else begin
               state_s     = IDLE;
            end
         end
         WALK: begin
            flush_idx_s = flush_idx_r + SET_W'(1);
            if (flush_idx_r == LAST_SET) begin
               state_s = DONE;
            end else begin
               state_s = WALK;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Entry state: the walk clears one whole set per cycle; otherwise host
   // strobes apply with invalidate over load over mark_dirty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_r[s] <= '0;
            dirty_r[s] <= '0;
            ptr_r[s]   <= '0;
         end
      end else if (state_r == WALK) begin
         valid_r[flush_idx_r] <= '0;
         dirty_r[flush_idx_r] <= '0;
         ptr_r[flush_idx_r]   <= '0;
      end else if (accept_s) begin
         if (bus.invalidate) begin
            valid_r[bus.set_sel][bus.way_sel] <= 1'b0;
            dirty_r[bus.set_sel][bus.way_sel] <= 1'b0;
         end else if (bus.load) begin
            valid_r[bus.set_sel][bus.way_sel] <= 1'b1;
            dirty_r[bus.set_sel][bus.way_sel] <= bus.mark_dirty;
            ptr_r[bus.set_sel]                <= bus.way_sel + WAY_ONE;
         end else if (bus.mark_dirty && valid_r[bus.set_sel][bus.way_sel]) begin
            dirty_r[bus.set_sel][bus.way_sel] <= 1'b1;
         end
      end
   end

   // Victim: lowest invalid way, falling back to the set's round-robin pointer.
   always_comb begin
      set_valid_s = valid_r[bus.set_sel];
      victim_s    = ptr_r[bus.set_sel];
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         victim_s = set_valid_s[w] ? victim_s : WAY_W'(w);
      end
   end

   assign bus.valid_vec  = valid_r[bus.set_sel];
   assign bus.dirty_vec  = dirty_r[bus.set_sel];
   assign bus.valid_sig  = valid_r[bus.set_sel][bus.way_sel];
   assign bus.dirty_sig  = dirty_r[bus.set_sel][bus.way_sel];
   assign bus.victim_way = victim_s;
   assign bus.flush_busy = (state_r != IDLE);
   assign bus.flush_done = (state_r == DONE);
endmodule

// File: tb/tb_cache_state_array.sv
// Bench for cache_state_array: directed and random updates checked against a
// behavioural set/way model, plus flush walk timing on two configurations.
module tb_cache_state_array;
   localparam int NW   = 2;
   localparam int NS   = 8;
   localparam int NW_B = 4;
   localparam int NS_B = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_state_array_if #(.NUM_WAYS(NW), .NUM_SETS(NS)) bus_a ();
   cache_state_array_if #(.NUM_WAYS(NW_B), .NUM_SETS(NS_B)) bus_b ();

   cache_state_array #(.NUM_WAYS(NW), .NUM_SETS(NS)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   cache_state_array #(.NUM_WAYS(NW_B), .NUM_SETS(NS_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   int n_pass  = 0;
   int n_total = 0;

   // reference model for dut_a
   bit m_valid [NS][NW];
   bit m_dirty [NS][NW];
   int m_ptr   [NS];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_clear();
      for (int s = 0; s < NS; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < NW; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
         end
      end
   endtask

   task automatic model_apply(input int s, input int w, input bit ld, input bit md, input bit inv);
      if (inv) begin
         m_valid[s][w] = 1'b0;
         m_dirty[s][w] = 1'b0;
      end else if (ld) begin
         m_valid[s][w] = 1'b1;
         m_dirty[s][w] = md;
         m_ptr[s]      = (w + 1) % NW;
      end else if (md && m_valid[s][w]) begin
         m_dirty[s][w] = 1'b1;
      end
   endtask

   function automatic logic [31:0] m_vec(input int s, input bit want_dirty);
      logic [31:0] v;
      v = 32'd0;
      for (int w = 0; w < NW; w++) v[w] = want_dirty ? m_dirty[s][w] : m_valid[s][w];
      return v;
   endfunction

   function automatic logic [31:0] m_victim(input int s);
      for (int w = 0; w < NW; w++) if (!m_valid[s][w]) return 32'(w);
      return 32'(m_ptr[s]);
   endfunction

   task automatic check_entry(input string tag, input int s, input int w);
      check({tag, ".valid_vec"},  32'(bus_a.valid_vec),  m_vec(s, 1'b0));
      check({tag, ".dirty_vec"},  32'(bus_a.dirty_vec),  m_vec(s, 1'b1));
      check({tag, ".victim_way"}, 32'(bus_a.victim_way), m_victim(s));
      check({tag, ".valid_sig"},  32'(bus_a.valid_sig),  32'(m_valid[s][w]));
      check({tag, ".dirty_sig"},  32'(bus_a.dirty_sig),  32'(m_dirty[s][w]));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input int s, input int w, input bit ld, input bit md, input bit inv, input bit fr);
      bus_a.set_sel    = 3'(s);
      bus_a.way_sel    = 1'(w);
      bus_a.load       = ld;
      bus_a.mark_dirty = md;
      bus_a.invalidate = inv;
      bus_a.flush_req  = fr;
   endtask

   task automatic op_a(input string tag, input int s, input int w, input bit ld, input bit md, input bit inv);
      drive_a(s, w, ld, md, inv, 1'b0);
      tick();
      drive_a(s, w, 1'b0, 1'b0, 1'b0, 1'b0);
      model_apply(s, w, ld, md, inv);
      check_entry(tag, s, w);
   endtask

   task automatic load_b(input int s, input int w);
      bus_b.set_sel = 4'(s);
      bus_b.way_sel = 2'(w);
      bus_b.load    = 1'b1;
      tick();
      bus_b.load    = 1'b0;
   endtask

   initial begin : main
      int cnt;
      int done_cnt;
      bit seen_done;
      bit seen_busy;
      int s;
      int w;

      drive_a(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus_b.set_sel = '0; bus_b.way_sel = '0; bus_b.load = 1'b0;
      bus_b.mark_dirty = 1'b0; bus_b.invalidate = 1'b0; bus_b.flush_req = 1'b0;
      model_clear();

      // reset state, every set
      #1;
      check("rst.flush_busy", 32'(bus_a.flush_busy), 32'd0);
      check("rst.flush_done", 32'(bus_a.flush_done), 32'd0);
      for (int i = 0; i < NS; i++) begin
         bus_a.set_sel = 3'(i);
         #1;
         check("rst.victim", 32'(bus_a.victim_way), 32'd0);
         check("rst.valid_vec", 32'(bus_a.valid_vec), 32'd0);
      end
      #2 rst_n = 1'b1;
      tick();

      // single load, then set 5 pointer wrap
      op_a("load_s3w0", 3, 0, 1'b1, 1'b0, 1'b0);
      check("load_s3w0.vec_lit", 32'(bus_a.valid_vec), 32'b01);
      check("load_s3w0.vic_lit", 32'(bus_a.victim_way), 32'd1);
      op_a("s5w0", 5, 0, 1'b1, 1'b0, 1'b0);
      op_a("s5w1", 5, 1, 1'b1, 1'b0, 1'b0);
      check("s5w1.vic_lit", 32'(bus_a.victim_way), 32'd0);
      op_a("s5w1_again", 5, 1, 1'b1, 1'b0, 1'b0);
      check("s5w1_again.vic_lit", 32'(bus_a.victim_way), 32'd0);

      // priority and dirty-on-invalid
      op_a("s2w1_all", 2, 1, 1'b1, 1'b1, 1'b1);
      check("s2w1_all.valid_lit", 32'(bus_a.valid_sig), 32'd0);
      op_a("s2w1_md_invalid", 2, 1, 1'b0, 1'b1, 1'b0);
      check("s2w1_md.dirty_lit", 32'(bus_a.dirty_sig), 32'd0);
      op_a("s2w1_ld_md", 2, 1, 1'b1, 1'b1, 1'b0);
      check("s2w1_ld_md.dirty_lit", 32'(bus_a.dirty_sig), 32'd1);

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         op_a("rand", int'($urandom_range(0, NS - 1)), int'($urandom_range(0, NW - 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
      end

      // fill everything, dirty a subset
      for (int i = 0; i < NS; i++)
         for (int j = 0; j < NW; j++)
            op_a("fill", i, j, 1'b1, ((i + j) % 3 == 0), 1'b0);

      // flush requested together with a load: load lands, walk follows
      op_a("pre_inv_s6", 6, 0, 1'b0, 1'b0, 1'b1);
      drive_a(6, 0, 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      drive_a(6, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("ld_flush.valid_sig", 32'(bus_a.valid_sig), 32'd1);
      check("ld_flush.busy", 32'(bus_a.flush_busy), 32'd1);
      cnt = 0;
      done_cnt = 0;
      for (int g = 0; g < 64 && bus_a.flush_busy; g++) begin
         cnt++;
         if (bus_a.flush_done) begin
            done_cnt++;
            check("walk.done_position", 32'(cnt), 32'(NS + 1));
         end
         drive_a(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, NW - 1)),
                 1'b1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 1'b1);
         tick();
      end
      drive_a(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("walk.busy_cycles", 32'(cnt), 32'(NS + 1));
      check("walk.done_pulses", 32'(done_cnt), 32'd1);
      check("walk.after_busy", 32'(bus_a.flush_busy), 32'd0);
      check("walk.after_done", 32'(bus_a.flush_done), 32'd0);
      model_clear();
      for (int i = 0; i < NS; i++) begin
         bus_a.set_sel = 3'(i);
         #1;
         check_entry("post_flush", i, 0);
      end

      // reset in the middle of a walk
      op_a("pre_abort_s7", 7, 1, 1'b1, 1'b1, 1'b0);
      drive_a(7, 1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      drive_a(7, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); tick(); tick();
      check("abort.busy_before", 32'(bus_a.flush_busy), 32'd1);
      check("abort.s7_before", 32'(bus_a.valid_vec), 32'b10);
      rst_n = 1'b0;
      #1;
      check("abort.busy", 32'(bus_a.flush_busy), 32'd0);
      check("abort.done", 32'(bus_a.flush_done), 32'd0);
      check("abort.valid_vec", 32'(bus_a.valid_vec), 32'd0);
      check("abort.victim", 32'(bus_a.victim_way), 32'd0);
      #1 rst_n = 1'b1;
      model_clear();
      seen_done = 1'b0;
      seen_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen_done = seen_done | bus_a.flush_done;
         seen_busy = seen_busy | bus_a.flush_busy;
      end
      check("abort.no_done", 32'(seen_done), 32'd0);
      check("abort.no_busy", 32'(seen_busy), 32'd0);

      // 4-way / 16-set configuration
      load_b(9, 2);
      check("b.vec_w2", 32'(bus_b.valid_vec), 32'b0100);
      check("b.vic_w2", 32'(bus_b.victim_way), 32'd0);
      load_b(9, 0);
      load_b(9, 1);
      check("b.vic_w012", 32'(bus_b.victim_way), 32'd3);
      load_b(9, 3);
      check("b.vic_full_wrap", 32'(bus_b.victim_way), 32'd0);
      load_b(9, 1);
      check("b.vic_full_ptr", 32'(bus_b.victim_way), 32'd2);
      bus_b.flush_req = 1'b1;
      tick();
      bus_b.flush_req = 1'b0;
      cnt = 0;
      done_cnt = 0;
      for (int g = 0; g < 64 && bus_b.flush_busy; g++) begin
         cnt++;
         if (bus_b.flush_done) done_cnt++;
         tick();
      end
      check("b.busy_cycles", 32'(cnt), 32'(NS_B + 1));
      check("b.done_pulses", 32'(done_cnt), 32'd1);
      check("b.vec_after", 32'(bus_b.valid_vec), 32'd0);
      check("b.vic_after", 32'(bus_b.victim_way), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
